// File: rtl/gen_frecv.sv
// gen_frecv -- programmable square-wave generator driven by a phase accumulator.
//
// A frequency word from the front-panel selector is scaled by STEP_PER_HZ into a
// phase increment. The accumulator MSB is the output wave. New words wait in a
// pending register and are swapped in on an accumulator wrap, so the output never
// shows a truncated phase. The active word is reported back for display.
//
// Optional feature macro: GEN_FRECV_CLAMP_EN
//   defined   : captured words are clamped to [1, 9999] (word 0 becomes 1)
//   undefined : words are taken as-is; word 0 stops the output at the next boundary
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-high
//   enable      in   run enable (level)
//   frecv_sel   in   requested frequency word [width]
//   q_modif     in   load strobe, captures frecv_sel on every high cycle
//   out_wave    out  square wave (registered accumulator MSB)
//   out_tick    out  one-cycle pulse after each accumulator wrap
//   frecv_activ out  word currently driving the accumulator [width]
//   upd_pend    out  a captured word is waiting for a period boundary
//   upd_done    out  one-cycle pulse when a captured word becomes active
module gen_frecv #(
  parameter int width       = 16,
  parameter int ACC_W       = 32,
  parameter int STEP_PER_HZ = 86
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [width-1:0] frecv_sel,
  input  logic             q_modif,
  output logic             out_wave,
  output logic             out_tick,
  output logic [width-1:0] frecv_activ,
  output logic             upd_pend,
  output logic             upd_done
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t             state, state_n;
  logic [ACC_W-1:0]   acc, acc_n;
  logic [width-1:0]   pend_word, pend_n;
  logic [width-1:0]   activ_n;
  logic               wave_n, tick_n, upd_pend_n, upd_done_n;

  logic [width-1:0]   sel_c;
  logic [width-1:0]   apply_word;
  logic [ACC_W-1:0]   inc;
  logic [ACC_W:0]     sum_w;
  logic               carry;

  // Word conditioning before it enters the pending register.
`ifdef GEN_FRECV_CLAMP_EN
  always_comb begin
    if (frecv_sel == '0)
      sel_c = width'(1);
    else if (32'(frecv_sel) > 32'd9999)
      sel_c = width'(9999);
    else
      sel_c = frecv_sel;
  end
`else
  assign sel_c = frecv_sel;
`endif

  // Increment is the active word times the step constant, truncated to ACC_W.
  assign inc   = ACC_W'(frecv_activ) * ACC_W'(STEP_PER_HZ);
  assign sum_w = {1'b0, acc} + {1'b0, inc};
  assign carry = sum_w[ACC_W];

  // A fresh capture on this cycle wins over an older pending word.
  assign apply_word = q_modif ? sel_c : pend_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      out_wave    <= 1'b0;
      out_tick    <= 1'b0;
      frecv_activ <= '0;
      pend_word   <= '0;
      upd_pend    <= 1'b0;
      upd_done    <= 1'b0;
    end else begin
      state       <= state_n;
      acc         <= acc_n;
      out_wave    <= wave_n;
      out_tick    <= tick_n;
      frecv_activ <= activ_n;
      pend_word   <= pend_n;
      upd_pend    <= upd_pend_n;
      upd_done    <= upd_done_n;
    end
  end

  always_comb begin
    state_n    = state;
    acc_n      = acc;
    wave_n     = 1'b0;
    tick_n     = 1'b0;
    activ_n    = frecv_activ;
    pend_n     = pend_word;
    upd_pend_n = upd_pend;
    upd_done_n = 1'b0;

    unique case (state)
      IDLE: begin
        acc_n = '0;
        // No period boundary to wait for: apply captures (or a word left
        // pending by a wrap that stopped the output) right away.
        if (q_modif || upd_pend) begin
          activ_n    = apply_word;
          upd_done_n = 1'b1;
          upd_pend_n = 1'b0;
        end
        if (enable && activ_n != '0) state_n = RUN;
      end

      RUN, PEND: begin
        if (!enable) begin
          state_n = IDLE;
          acc_n   = '0;
          if (q_modif || upd_pend) begin
            activ_n    = apply_word;
            upd_done_n = 1'b1;
            upd_pend_n = 1'b0;
          end
        end else begin
          acc_n  = sum_w[ACC_W-1:0];
          wave_n = sum_w[ACC_W-1];
          tick_n = carry;
          if (state == PEND && carry) begin
            activ_n    = pend_word;
            upd_done_n = 1'b1;
            upd_pend_n = 1'b0;
            if (pend_word == '0) begin
              state_n = IDLE;
              acc_n   = '0;
              wave_n  = 1'b0;
            end else begin
              state_n = RUN;
            end
          end
          // A capture always lands in pending; on a wrap in PEND it becomes
          // the next word behind the one just applied.
          if (q_modif) begin
            pend_n     = sel_c;
            upd_pend_n = 1'b1;
            if (state_n == RUN) state_n = PEND;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/gen_frecv.md
# gen_frecv

Programmable square-wave generator that consumes the frequency word and update strobe from the front-panel frequency selector. A phase accumulator produces `out_wave`. New words are applied glitch-free at the next period boundary, and the active word is reported back for display. Sits between the selector and the output pin driver.

## Interface
- `width`, 16: frequency word width.
- `ACC_W`, 32: phase accumulator width.
- `STEP_PER_HZ`, 86: constant multiplier, word to phase increment (≈2^32/50 MHz).
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high; one clock domain only.
- `enable` in 1: generator run enable, level.
- `frecv_sel` in `width`: requested frequency word.
- `q_modif` in 1: load strobe; `frecv_sel` is captured on every cycle it is high.
- `out_wave` out 1: square wave, equal to accumulator MSB (registered).
- `out_tick` out 1: one-cycle pulse on each accumulator wrap.
- `frecv_activ` out `width`: word currently driving the accumulator.
- `upd_pend` out 1: captured word is waiting for a period boundary.
- `upd_done` out 1: one-cycle pulse when a captured word becomes active.

## Operation
- Reset values:
  - accumulator = 0, `out_wave` = 0, `out_tick` = 0.
  - `frecv_activ` = 0, pending register = 0.
  - `upd_pend` = 0, `upd_done` = 0.
  - state = IDLE.
- Increment = `frecv_activ` × `STEP_PER_HZ`, truncated to `ACC_W` bits. The accumulator adds the increment modulo 2^`ACC_W`. A wrap is the carry out of that addition.
- States:
  - **IDLE**: accumulator held at 0, `out_wave` = 0. Entered from reset, when `enable` = 0, or when a boundary applies word 0. A capture in IDLE is applied on the next edge. Go to RUN if `enable` = 1 and the applied word ≠ 0.
  - **RUN**: accumulate every cycle. `q_modif` = 1 captures the word into pending → PEND.
  - **PEND**: keep accumulating with the old word and hold `upd_pend` = 1. Further `q_modif` pulses overwrite pending (last wins). On a wrap cycle, `frecv_activ` ← pending and `upd_done` pulses. Go to RUN, or IDLE if pending = 0.
- `enable` falling: go to IDLE immediately, clear the accumulator, force `out_wave` low, keep `frecv_activ`. A pending word is applied at once and `upd_done` pulses.
- `enable` rising with `frecv_activ` ≠ 0: RUN starts from accumulator 0.
- Simultaneous `q_modif` and wrap in PEND: the old pending word is applied, and the new word becomes pending (`upd_pend` stays 1).
- Simultaneous `q_modif` and wrap in RUN: the capture goes to PEND and waits for the next wrap.
- Reloading the same value still runs the full PEND/`upd_done` sequence.
- Reset mid-PEND discards the pending word.

## Timing
- `q_modif` high at edge N:
  - In RUN: `upd_pend` = 1 from N+1.
  - In IDLE: `frecv_activ` updated and `upd_done` = 1 at N+1.
- Application in PEND happens on the wrap edge:
  - The new increment is used from the following edge.
  - `upd_pend` falls on the same edge.
- `out_tick` asserts the cycle after the wrap edge, coincident with `out_wave` falling.
- Output period = 2^`ACC_W` / increment cycles, exact when this divides evenly.

## Configuration
- `GEN_FRECV_CLAMP_EN` defined:
  - Captured words are clamped to [1, 9999] before entering pending.
  - Word 0 becomes 1, so only `enable` can stop the output.
- `GEN_FRECV_CLAMP_EN` undefined: words are taken unmodified, and word 0 stops the output at the next boundary.

## Test plan
All scenarios use `ACC_W`=8, `STEP_PER_HZ`=1.
- Reset, `enable`=1, `q_modif` pulse with 64 → `upd_done` at N+1 (IDLE path); accumulator 0,64,128,192,0; `out_wave` low 2 / high 2 cycles; `out_tick` every 4 cycles.
- Running at 64, load 32 when accumulator = 64 → `upd_pend` = 1 until the wrap; no truncated high phase; period becomes 8 cycles.
- In PEND, pulse 16, then 128 before the wrap → `frecv_activ` = 128 after the wrap; exactly one `upd_done`.
- `q_modif` with 100 on the wrap edge while PEND holds 32 → 32 applied, 100 pending, `upd_pend` stays 1.
- Drop `enable` mid-high-phase → `out_wave` = 0 next edge; re-enable restarts from 0.
- Load 0 (macro off) → IDLE at the wrap, output low. Macro on: load 0 → `frecv_activ` = 1; load 20000 → `frecv_activ` = 9999.
